lsu_load_arbiter: RTL and testbench

LSU_LOAD_ARBITER -- requirements
Module: lsu_load_arbiter

---
 rtl/lsu_load_arbiter_if.sv | 80 ++++++++
 rtl/lsu_load_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_lsu_load_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_load_arbiter_if.sv
// -----------------------------------------------------------------------------
// lsu_load_arbiter_if
//
// Bundles the signals between the load functional units, the load arbiter and
// the LSU load port.
//
// Handshake semantics (all channels): a transfer happens in a cycle where the
// producer's valid and the consumer's ready are both high at the rising clock
// edge. A producer keeps valid and its payload stable until that edge. The
// response channel has no ready: every lsu_resp_valid cycle is one response,
// returned in request order.
//
// Signals
//   req_valid      [NREQ]       per-FU request valid
//   req_data       [NREQ*REQW]  per-FU payload, FU i at [i*REQW +: REQW]
//   req_ready      [NREQ]       per-FU accept, one-hot or zero
//   lsu_req_valid               request to the LSU
//   lsu_req_data   [REQW]       payload of the granted FU
//   lsu_req_ready               LSU accept
//   lsu_resp_valid              LSU response strobe
//   lsu_resp_data  [RSPW]       LSU response payload
//   resp_valid     [NREQ]       per-FU response strobe, one-hot or zero
//   resp_data      [RSPW]       response payload broadcast to every FU
//
// Modports
//   slave  : the arbiter's view
//   master : the view of the surrounding FUs + LSU (used by a bench)
// -----------------------------------------------------------------------------
`ifndef LSU_REQ_LEN
`define LSU_REQ_LEN 32
`endif
`ifndef LSU_RESP_LEN
`define LSU_RESP_LEN 32
`endif

interface lsu_load_arbiter_if #(
    parameter int NREQ = 2,
    parameter int REQW = `LSU_REQ_LEN,
    parameter int RSPW = `LSU_RESP_LEN
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*REQW-1:0] req_data;
    logic [NREQ-1:0]      req_ready;

    logic                 lsu_req_valid;
    logic [REQW-1:0]      lsu_req_data;
    logic                 lsu_req_ready;

    logic                 lsu_resp_valid;
    logic [RSPW-1:0]      lsu_resp_data;

    logic [NREQ-1:0]      resp_valid;
    logic [RSPW-1:0]      resp_data;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output lsu_req_valid,
        output lsu_req_data,
        input  lsu_req_ready,
        input  lsu_resp_valid,
        input  lsu_resp_data,
        output resp_valid,
        output resp_data
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  lsu_req_valid,
        input  lsu_req_data,
        output lsu_req_ready,
        output lsu_resp_valid,
        output lsu_resp_data,
        input  resp_valid,
        input  resp_data
    );
endinterface

// File: rtl/lsu_load_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_load_arbiter
//
// Shares one LSU load port between NREQ load functional units.
//   * Round-robin grant, combinational (zero-cycle request path).
//   * A grant that is presented but not accepted is locked in a register and
//     held until the LSU takes it.
//   * An ODEPTH-entry FIFO remembers {fu_id, killed} for each request in
//     flight so in-order LSU responses can be steered back to the right FU.
//   * Flush marks everything in flight as killed; killed responses still drain
//     through the FIFO but raise no resp_valid.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-low reset
//   Flush      pipeline flush
//   bus        lsu_load_arbiter_if.slave (FU request/response and LSU port)
//   dbg_state  1 while a grant is locked
//   dbg_count  outstanding FIFO occupancy
//   dbg_rr_ptr round-robin pointer
// -----------------------------------------------------------------------------
`ifndef LSU_REQ_LEN
`define LSU_REQ_LEN 32
`endif
`ifndef LSU_RESP_LEN
`define LSU_RESP_LEN 32
`endif

module lsu_load_arbiter #(
    parameter  int NREQ   = 2,
    parameter  int REQW   = `LSU_REQ_LEN,
    parameter  int RSPW   = `LSU_RESP_LEN,
    parameter  int ODEPTH = 4,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int AW     = (ODEPTH > 1) ? $clog2(ODEPTH) : 1,
    localparam int CW     = $clog2(ODEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Flush,
    lsu_load_arbiter_if.slave  bus,
    output logic               dbg_state,
    output logic [CW-1:0]      dbg_count,
    output logic [IDW-1:0]     dbg_rr_ptr
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_OPEN   = 1'b0,   // no grant held; arbiter picks freely
        ST_LOCKED = 1'b1    // a presented grant is waiting for lsu_req_ready
    } lock_state_t;

    lock_state_t       state;
    logic [IDW-1:0]    lock_id;
    logic              lock_killed;   // a Flush hit the locked request

    logic [IDW-1:0]    rr_ptr;

    logic [IDW-1:0]    fifo_id [ODEPTH];
    logic [ODEPTH-1:0] fifo_killed;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic              found;
    logic [IDW-1:0]    search_id;
    logic [IDW-1:0]    grant;
    logic [IDW-1:0]    next_rr;
    logic              full;
    logic              empty;
    logic              req_valid_o;
    logic              req_fire;
    logic              resp_pop;
    logic              push_killed;
    logic [REQW-1:0]   req_data_o;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   resp_valid_o;
    logic [RSPW-1:0]   rsp_payload;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(ODEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Round-robin search: the first valid FU at or above rr_ptr wins; if there
    // is none, the lowest valid FU below rr_ptr wins (wrap-around).
    always_comb begin : rr_search
        found     = 1'b0;
        search_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i] && (IDW'(i) >= rr_ptr)) begin
                found     = 1'b1;
                search_id = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i]) begin
                found     = 1'b1;
                search_id = IDW'(i);
            end
        end
    end

    assign grant   = (state == ST_LOCKED) ? lock_id : search_id;
    assign next_rr = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    assign full    = (count == CW'(ODEPTH));
    assign empty   = (count == '0);

    // A locked request always stays presented: it was admitted while the FIFO
    // had room and nothing has been pushed since, so it can never overflow.
    // Full and Flush only hold back new, unlocked grants.
    assign req_valid_o = rst & ((state == ST_LOCKED) | (found & ~full & ~Flush));
    assign req_fire    = req_valid_o & bus.lsu_req_ready;

    // A locked request flushed in an earlier cycle is still pushed killed.
    assign push_killed = Flush | lock_killed;

    // A response with nothing outstanding is dropped without popping.
    assign resp_pop    = rst & bus.lsu_resp_valid & ~empty;

    always_comb begin : req_mux
        req_data_o  = '0;
        req_ready_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                req_data_o     = bus.req_data[i*REQW +: REQW];
                req_ready_o[i] = req_fire;
            end
        end
    end

    always_comb begin : resp_route
        resp_valid_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid_o[i] = resp_pop & ~fifo_killed[rd_ptr] &
                              (fifo_id[rd_ptr] == IDW'(i));
        end
    end

    assign rsp_payload       = bus.lsu_resp_data;

    assign bus.lsu_req_valid = req_valid_o;
    assign bus.lsu_req_data  = req_data_o;
    assign bus.req_ready     = req_ready_o;
    assign bus.resp_valid    = resp_valid_o;
    assign bus.resp_data     = rsp_payload;

    assign dbg_state         = (state == ST_LOCKED);
    assign dbg_count         = count;
    assign dbg_rr_ptr        = rr_ptr;

    // -------------------------------------------------------------------------
    // Lock FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_OPEN;
            lock_id     <= '0;
            lock_killed <= 1'b0;
        end else begin
            case (state)
                ST_OPEN: begin
                    // Presented but not taken: freeze the grant. Flush forces
                    // unlocked valid low, so a lock never forms in a Flush cycle.
                    if (req_valid_o && !bus.lsu_req_ready) begin
                        state       <= ST_LOCKED;
                        lock_id     <= search_id;
                        lock_killed <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (bus.lsu_req_ready) begin
                        state       <= ST_OPEN;
                        lock_killed <= 1'b0;
                    end else if (Flush) begin
                        lock_killed <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_OPEN;
                    lock_killed <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pointer: moves only when the LSU actually takes a request.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (req_fire) begin
            rr_ptr <= next_rr;
        end
    end

    // -------------------------------------------------------------------------
    // Outstanding FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ODEPTH; i++) begin
                fifo_id[i] <= '0;
            end
            fifo_killed <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            // Killing every slot covers all valid entries; an empty slot's bit
            // is overwritten when it is next pushed.
            if (Flush) begin
                fifo_killed <= '1;
            end
            if (req_fire) begin
                fifo_id[wr_ptr]     <= grant;
                fifo_killed[wr_ptr] <= push_killed;
                wr_ptr              <= ptr_inc(wr_ptr);
            end
            if (resp_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({req_fire, resp_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
    resp_on_empty: assert property (@(posedge clk) disable iff (!rst)
        !(bus.lsu_resp_valid && empty));

    no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(req_fire && full && !resp_pop));

endmodule

// File: tb/tb_lsu_load_arbiter.sv
module tb_lsu_load_arbiter;

    localparam int NREQ   = 2;
    localparam int REQW   = 32;
    localparam int RSPW   = 32;
    localparam int ODEPTH = 4;
    localparam int CW     = 3;
    localparam int IDW    = 1;

    // ---------------------------------------------------------------- clock/reset
    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush = 1'b0;
    logic           dbg_state;
    logic [CW-1:0]  dbg_count;
    logic [IDW-1:0] dbg_rr_ptr;

    always #5 clk = ~clk;

    lsu_load_arbiter_if #(.NREQ(NREQ), .REQW(REQW), .RSPW(RSPW)) bus ();

    lsu_load_arbiter #(
        .NREQ(NREQ), .REQW(REQW), .RSPW(RSPW), .ODEPTH(ODEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Flush      (flush),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_count  (dbg_count),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    logic [NREQ+REQW-1:0] exp_req_q[$];   // {req_ready one-hot, lsu_req_data}
    logic [NREQ+RSPW-1:0] exp_rsp_q[$];   // {resp_valid, resp_data}
    logic [NREQ+REQW-1:0] mon_req_e;
    logic [NREQ+RSPW-1:0] mon_rsp_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: no expected entry queued at %0t", name, $time);
    endtask

    // Monitor: outputs are combinational from inputs driven #1 after posedge,
    // so the falling edge sees the values that the next rising edge commits.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.lsu_req_valid && bus.lsu_req_ready) begin
                if (exp_req_q.size() == 0) fail_now("req_unexpected");
                else begin
                    mon_req_e = exp_req_q.pop_front();
                    check("req_hs", 64'({bus.req_ready, bus.lsu_req_data}), 64'(mon_req_e));
                end
            end else begin
                check("req_ready_idle", 64'(bus.req_ready), 64'd0);
            end
            if (bus.lsu_resp_valid) begin
                if (exp_rsp_q.size() == 0) fail_now("resp_unexpected");
                else begin
                    mon_rsp_e = exp_rsp_q.pop_front();
                    check("resp", 64'({bus.resp_valid, bus.resp_data}), 64'(mon_rsp_e));
                end
            end else begin
                check("resp_idle", 64'(bus.resp_valid), 64'd0);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [NREQ-1:0] v, input logic [REQW-1:0] d0,
                           input logic [REQW-1:0] d1, input logic rdy);
        bus.req_valid     = v;
        bus.req_data      = {d1, d0};
        bus.lsu_req_ready = rdy;
    endtask

    task automatic expect_req(input logic [NREQ-1:0] fu, input logic [REQW-1:0] d);
        exp_req_q.push_back({fu, d});
    endtask

    task automatic send_resp(input logic [RSPW-1:0] d, input logic [NREQ-1:0] fu);
        bus.lsu_resp_valid = 1'b1;
        bus.lsu_resp_data  = d;
        exp_rsp_q.push_back({fu, d});
        step();
        bus.lsu_resp_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset with requests present: outputs must stay quiet.
        set_req(2'b11, 32'hA000_0000, 32'hB000_0000, 1'b1);
        bus.lsu_resp_valid = 1'b0;
        bus.lsu_resp_data  = '0;
        #3;
        check("rst_lsu_req_valid", 64'(bus.lsu_req_valid), 64'd0);
        check("rst_req_ready",     64'(bus.req_ready),     64'd0);
        check("rst_resp_valid",    64'(bus.resp_valid),    64'd0);
        check("rst_count",         64'(dbg_count),         64'd0);
        check("rst_rr_ptr",        64'(dbg_rr_ptr),        64'd0);
        check("rst_state",         64'(dbg_state),         64'd0);
        step();
        step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        step();

        // Contention: grants 0,1,0,1.
        set_req(2'b11, 32'hA000_0001, 32'hB000_0001, 1'b1); expect_req(2'b01, 32'hA000_0001); step();
        set_req(2'b11, 32'hA000_0002, 32'hB000_0001, 1'b1); expect_req(2'b10, 32'hB000_0001); step();
        set_req(2'b11, 32'hA000_0002, 32'hB000_0003, 1'b1); expect_req(2'b01, 32'hA000_0002); step();
        set_req(2'b11, 32'hA000_0004, 32'hB000_0003, 1'b1); expect_req(2'b10, 32'hB000_0003); step();

        // Full: four outstanding blocks new grants, even in a pop cycle.
        set_req(2'b01, 32'hA000_0005, 32'h0, 1'b1);
        #2;
        check("full_blocks_valid", 64'(bus.lsu_req_valid), 64'd0);
        check("full_count",        64'(dbg_count),         64'd4);
        check("full_rr_ptr",       64'(dbg_rr_ptr),        64'd0);
        step();
        bus.lsu_resp_valid = 1'b1;
        bus.lsu_resp_data  = 32'hD000_0001;
        exp_rsp_q.push_back({2'b01, 32'hD000_0001});
        expect_req(2'b01, 32'hA000_0005);
        #2;
        check("full_pop_cycle_valid", 64'(bus.lsu_req_valid), 64'd0);
        step();
        bus.lsu_resp_valid = 1'b0;
        #2;
        check("full_release_valid", 64'(bus.lsu_req_valid), 64'd1);
        step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        send_resp(32'hD000_0002, 2'b10);
        send_resp(32'hD000_0003, 2'b01);
        send_resp(32'hD000_0004, 2'b10);
        send_resp(32'hD000_0005, 2'b01);
        #2;
        check("drain_count", 64'(dbg_count), 64'd0);

        // Backpressure lock: FU1 locked while FU0 arrives with rr_ptr = 0.
        set_req(2'b10, 32'h0, 32'hB000_0006, 1'b1); expect_req(2'b10, 32'hB000_0006); step();
        set_req(2'b10, 32'h0, 32'hB000_0007, 1'b0);
        #2;
        check("lock_first_valid", 64'(bus.lsu_req_valid), 64'd1);
        check("lock_rr_ptr",      64'(dbg_rr_ptr),        64'd0);
        step();
        #2;
        check("lock_state", 64'(dbg_state),        64'd1);
        check("lock_data",  64'(bus.lsu_req_data), 64'hB000_0007);
        step();
        set_req(2'b11, 32'hA000_0008, 32'hB000_0007, 1'b0);
        #2;
        check("lock_hold_data",  64'(bus.lsu_req_data), 64'hB000_0007);
        check("lock_hold_ready", 64'(bus.req_ready),    64'd0);
        step();
        set_req(2'b11, 32'hA000_0008, 32'hB000_0007, 1'b1); expect_req(2'b10, 32'hB000_0007); step();
        set_req(2'b01, 32'hA000_0008, 32'h0, 1'b1);         expect_req(2'b01, 32'hA000_0008); step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        send_resp(32'hD000_0006, 2'b10);
        send_resp(32'hD000_0007, 2'b10);
        send_resp(32'hD000_0008, 2'b01);

        // Flush with three outstanding (FUs 0,1,0) and no lock.
        set_req(2'b01, 32'hA000_0009, 32'h0, 1'b1); expect_req(2'b01, 32'hA000_0009); step();
        set_req(2'b10, 32'h0, 32'hB000_000A, 1'b1); expect_req(2'b10, 32'hB000_000A); step();
        set_req(2'b01, 32'hA000_000B, 32'h0, 1'b1); expect_req(2'b01, 32'hA000_000B); step();
        set_req(2'b10, 32'h0, 32'hB000_000C, 1'b1);
        flush = 1'b1;
        #2;
        check("flush_blocks_valid", 64'(bus.lsu_req_valid), 64'd0);
        check("flush_blocks_ready", 64'(bus.req_ready),     64'd0);
        step();
        flush = 1'b0;
        expect_req(2'b10, 32'hB000_000C);
        step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        send_resp(32'hD000_0009, 2'b00);
        send_resp(32'hD000_000A, 2'b00);
        send_resp(32'hD000_000B, 2'b00);
        send_resp(32'hD000_000C, 2'b10);

        // Flush on a locked request: stays presented, response suppressed.
        set_req(2'b01, 32'hA000_000D, 32'h0, 1'b0);
        step();
        flush = 1'b1;
        #2;
        check("flush_lock_valid", 64'(bus.lsu_req_valid), 64'd1);
        check("flush_lock_data",  64'(bus.lsu_req_data),  64'hA000_000D);
        step();
        flush = 1'b0;
        #2;
        check("flush_lock_hold", 64'(bus.lsu_req_valid), 64'd1);
        step();
        bus.lsu_req_ready = 1'b1;
        expect_req(2'b01, 32'hA000_000D);
        step();
        set_req(2'b10, 32'h0, 32'hB000_000E, 1'b1); expect_req(2'b10, 32'hB000_000E); step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        send_resp(32'hD000_000D, 2'b00);
        send_resp(32'hD000_000E, 2'b10);

        // Async reset with two outstanding and a locked request.
        set_req(2'b10, 32'h0, 32'hB000_000F, 1'b1); expect_req(2'b10, 32'hB000_000F); step();
        set_req(2'b01, 32'hA000_0010, 32'h0, 1'b1); expect_req(2'b01, 32'hA000_0010); step();
        set_req(2'b01, 32'hA000_0011, 32'h0, 1'b0);
        step();
        #2;
        check("pre_rst_count",  64'(dbg_count),  64'd2);
        check("pre_rst_rr_ptr", 64'(dbg_rr_ptr), 64'd1);
        rst = 1'b0;
        #1;
        check("arst_lsu_req_valid", 64'(bus.lsu_req_valid), 64'd0);
        check("arst_req_ready",     64'(bus.req_ready),     64'd0);
        check("arst_resp_valid",    64'(bus.resp_valid),    64'd0);
        check("arst_count",         64'(dbg_count),         64'd0);
        check("arst_rr_ptr",        64'(dbg_rr_ptr),        64'd0);
        check("arst_state",         64'(dbg_state),         64'd0);
        step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #2;
        check("post_rst_count",  64'(dbg_count),  64'd0);
        check("post_rst_rr_ptr", 64'(dbg_rr_ptr), 64'd0);
        set_req(2'b11, 32'hA000_0013, 32'hB000_0014, 1'b1); expect_req(2'b01, 32'hA000_0013); step();
        set_req(2'b11, 32'hA000_0015, 32'hB000_0014, 1'b1); expect_req(2'b10, 32'hB000_0014); step();
        set_req(2'b00, 32'h0, 32'h0, 1'b0);
        send_resp(32'hD000_0013, 2'b01);
        send_resp(32'hD000_0014, 2'b10);
        step();

        // ------------------------------------------------------------ report
        check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
        check("rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
